// File: rtl/rr_arb20_if.sv
// Request/grant bundle between the requesters and the rr_arb20 arbiter.
interface rr_arb20_if;
    logic [19:0] req;
    logic        done;
    logic [19:0] gnt;
    logic [4:0]  gnt_id;
    logic        busy;
    logic        timeout;

    modport master (output req, done, input gnt, gnt_id, busy, timeout);
    modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_arb20.sv
// 20-way round-robin arbiter with registered one-hot grant and encoded owner index.
// Optional forced release after TIMEOUT held cycles when ARB_TIMEOUT_EN is defined.
module rr_arb20 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       nrst,
    rr_arb20_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  gnt_id_q, gnt_id_d;
    logic [19:0] gnt_q, gnt_d;
    logic [4:0]  pick_id;
    logic        pick_vld;
    logic        owner_rel;
    logic        hold_hit;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arb20: TIMEOUT must be in 1..255");
    end

    // Search ptr, ptr+1, ... modulo 20 so indices 20..31 are never visited.
    always_comb begin
        logic [5:0] sum;
        pick_vld = 1'b0;
        pick_id  = 5'd0;
        sum      = 6'd0;
        for (int off = 0; off < 20; off++) begin
            sum = {1'b0, ptr_q} + 6'(off);
            if (sum >= 6'd20) sum = sum - 6'd20;
            if (!pick_vld && bus.req[sum[4:0]]) begin
                pick_vld = 1'b1;
                pick_id  = sum[4:0];
            end
        end
    end

    assign owner_rel = bus.done || !bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign hold_hit = (state_q == GRANT) && (cnt_q == HOLD_MAX);

    // Counter sits at zero while idle, so it is already clear on entry to GRANT.
    always_comb begin
        cnt_d     = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
        timeout_d = hold_hit && !owner_rel;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign hold_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d  = GRANT;
                    gnt_d    = 20'd1 << pick_id;
                    gnt_id_d = pick_id;
                end
            end
            GRANT: begin
                if (owner_rel || hold_hit) begin
                    state_d  = IDLE;
                    gnt_d    = 20'd0;
                    gnt_id_d = 5'd0;
                    ptr_d    = (gnt_id_q == 5'd19) ? 5'd0 : gnt_id_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            ptr_q    <= 5'd0;
            gnt_q    <= 20'd0;
            gnt_id_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q == GRANT);
endmodule

// File: tb/tb_rr_arb20.sv
// Directed bench for rr_arb20: each driven cycle queues its expected outputs, a monitor checks them.
module tb_rr_arb20;
    logic clk = 1'b0;
    logic nrst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rr_arb20_if bus();

    rr_arb20 #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        logic [19:0] gnt;
        logic [4:0]  id;
        logic        busy;
        logic        to;
    } exp_t;

    exp_t sb_q[$];

    // Drive one cycle of inputs and queue what the outputs must read after the next edge.
    task automatic step(input logic [19:0] r, input logic d, input logic n,
                        input string name, input logic eb, input int eid, input logic eto);
        exp_t e;
        @(negedge clk);
        #1;
        bus.req  = r;
        bus.done = d;
        nrst     = n;
        e.name = name;
        e.busy = eb;
        e.id   = eb ? 5'(eid) : 5'd0;
        e.gnt  = eb ? (20'd1 << eid) : 20'd0;
        e.to   = eto;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_assert++;
            if (bus.gnt !== e.gnt || bus.gnt_id !== e.id || bus.busy !== e.busy || bus.timeout !== e.to) begin
                n_fail++;
                $display("FAIL %s: got gnt=%h id=%0d busy=%b timeout=%b, want gnt=%h id=%0d busy=%b timeout=%b",
                         e.name, bus.gnt, bus.gnt_id, bus.busy, bus.timeout, e.gnt, e.id, e.busy, e.to);
            end else begin
                $display("ok   %s: gnt=%h id=%0d busy=%b timeout=%b", e.name, bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
            end
        end
    end

    initial begin
        nrst     = 1'b0;
        bus.req  = 20'd0;
        bus.done = 1'b0;

        // Reset with everything asserted
        step(20'hFFFFF, 1'b1, 1'b0, "rst0", 1'b0, 0, 1'b0);
        step(20'hFFFFF, 1'b1, 1'b0, "rst1", 1'b0, 0, 1'b0);
        step(20'h00000, 1'b0, 1'b1, "idle", 1'b0, 0, 1'b0);
        step(20'hFFFFF, 1'b0, 1'b1, "first_grant", 1'b1, 0, 1'b0);
        step(20'hFFFFF, 1'b1, 1'b1, "rel0", 1'b0, 0, 1'b0);

        // Single request, held three cycles then done
        step(20'h00020, 1'b0, 1'b1, "single", 1'b1, 5, 1'b0);
        for (int i = 0; i < 3; i++)
            step(20'h00020, 1'b0, 1'b1, $sformatf("hold5_%0d", i), 1'b1, 5, 1'b0);
        step(20'h00020, 1'b1, 1'b1, "done5", 1'b0, 0, 1'b0);
        step(20'hFFFFF, 1'b0, 1'b1, "after5", 1'b1, 6, 1'b0);
        step(20'hFFFFF, 1'b1, 1'b1, "rel6", 1'b0, 0, 1'b0);

        // Withdrawal of owner 7, then reset mid-grant
        step(20'hFFFFF, 1'b0, 1'b1, "g7", 1'b1, 7, 1'b0);
        step(20'hFFF7F, 1'b0, 1'b1, "withdraw7", 1'b0, 0, 1'b0);
        step(20'hFFFFF, 1'b0, 1'b1, "g8", 1'b1, 8, 1'b0);
        step(20'hFFFFF, 1'b0, 1'b0, "rst_mid", 1'b0, 0, 1'b0);

        // Fairness: done held high, grant every other cycle 0..19,0
        for (int i = 0; i < 21; i++) begin
            step(20'hFFFFF, 1'b1, 1'b1, $sformatf("fair%0d", i), 1'b1, i % 20, 1'b0);
            step(20'hFFFFF, 1'b1, 1'b1, $sformatf("fair_idle%0d", i), 1'b0, 0, 1'b0);
        end

        // Wrap: ptr=18 with bits 17 and 3 requesting
        step(20'h20000, 1'b0, 1'b1, "g17", 1'b1, 17, 1'b0);
        step(20'h20000, 1'b1, 1'b1, "r17", 1'b0, 0, 1'b0);
        step(20'h20008, 1'b0, 1'b1, "wrap3", 1'b1, 3, 1'b0);
        step(20'h20008, 1'b1, 1'b1, "r3", 1'b0, 0, 1'b0);
        step(20'h20008, 1'b0, 1'b1, "wrap17", 1'b1, 17, 1'b0);
        step(20'h20008, 1'b1, 1'b1, "r17b", 1'b0, 0, 1'b0);
        step(20'h80000, 1'b0, 1'b1, "g19", 1'b1, 19, 1'b0);
        step(20'h80000, 1'b1, 1'b1, "r19", 1'b0, 0, 1'b0);
        step(20'hFFFFF, 1'b0, 1'b1, "after19", 1'b1, 0, 1'b0);
        step(20'hFFFFF, 1'b1, 1'b1, "rel_a19", 1'b0, 0, 1'b0);

        // Hold behaviour with req[2] held and done low
        step(20'h00004, 1'b0, 1'b1, "to_grant", 1'b1, 2, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++)
            step(20'h00004, 1'b0, 1'b1, $sformatf("to_hold%0d", i), 1'b1, 2, 1'b0);
        step(20'h00004, 1'b0, 1'b1, "to_release", 1'b0, 0, 1'b1);
        step(20'h00004, 1'b0, 1'b1, "to_regrant", 1'b1, 2, 1'b0);
`else
        for (int i = 0; i < 310; i++)
            step(20'h00004, 1'b0, 1'b1, $sformatf("hold_long%0d", i), 1'b1, 2, 1'b0);
`endif
        step(20'h00000, 1'b0, 1'b1, "final_withdraw", 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
